pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives the active-low write enables (`*_nen_write`) and flush clears of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches, multi-cycle memory waits, and a halt/drain/resume sequence. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_detect.sv | 21 ++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control slice.
//   state_t    : hazard-controller FSM states (RUN, DRAIN, HALTED)
//   REG_ADDR_W : default register-file address width
//   REG_ZERO   : hard-wired zero register, never a real hazard source
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bus between the pipeline datapath and the hazard controller.
//   Hazard inputs : ifid_rs, ifid_rt, idex_rd, idex_mem_read, ex_branch_taken,
//                   mem_busy, halt_req, resume
//   Control output: *_nen_write (1 = hold), ifid_flush, idex_flush, halted,
//                   stall_count
//   master : datapath side (drives hazard inputs)
//   slave  : controller side (drives control outputs)
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int unsigned reg_addr_w = REG_ADDR_W,
  parameter int unsigned cnt_w      = 16
);

  logic [reg_addr_w-1:0] ifid_rs;
  logic [reg_addr_w-1:0] ifid_rt;
  logic [reg_addr_w-1:0] idex_rd;
  logic                  idex_mem_read;
  logic                  ex_branch_taken;
  logic                  mem_busy;
  logic                  halt_req;
  logic                  resume;

  logic                  pc_nen_write;
  logic                  ifid_nen_write;
  logic                  idex_nen_write;
  logic                  exmem_nen_write;
  logic                  memwb_nen_write;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  halted;
  logic [cnt_w-1:0]      stall_count;

  modport master (
    output ifid_rs, ifid_rt, idex_rd, idex_mem_read, ex_branch_taken,
           mem_busy, halt_req, resume,
    input  pc_nen_write, ifid_nen_write, idex_nen_write, exmem_nen_write,
           memwb_nen_write, ifid_flush, idex_flush, halted, stall_count
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_rd, idex_mem_read, ex_branch_taken,
           mem_busy, halt_req, resume,
    output pc_nen_write, ifid_nen_write, idex_nen_write, exmem_nen_write,
           memwb_nen_write, ifid_flush, idex_flush, halted, stall_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare.
//   rs, rt   : source registers of the instruction in ID
//   rd       : destination of the instruction in EX
//   mem_read : EX instruction is a load
//   load_use : ID needs the load result that is not yet available
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int unsigned reg_addr_w = REG_ADDR_W
) (
  input  logic [reg_addr_w-1:0] rs,
  input  logic [reg_addr_w-1:0] rt,
  input  logic [reg_addr_w-1:0] rd,
  input  logic                  mem_read,
  output logic                  load_use
);

  assign load_use = mem_read && (rd != reg_addr_w'(REG_ZERO)) &&
                    ((rd == rs) || (rd == rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   hz    : hazard inputs in, register write enables / flushes / halted /
//           saturating stall counter out (see pipeline_hazard_ctrl_if)
// Outputs are combinational so hazards are answered in the same cycle.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned reg_addr_w   = REG_ADDR_W,
  parameter int unsigned cnt_w        = 16,
  parameter int unsigned drain_cycles = 4
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned DCNT_W = $clog2(drain_cycles + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(drain_cycles - 1);

  state_t            state, state_next;
  logic [DCNT_W-1:0] dcnt, dcnt_next;
  logic [cnt_w-1:0]  stall_q;
  logic              load_use;
  logic              stall_inc;

  logic pc_nen, ifid_nen, idex_nen, exmem_nen, memwb_nen;
  logic ifid_fl, idex_fl;

  hazard_detect #(
    .reg_addr_w(reg_addr_w)
  ) u_hazard_detect (
    .rs       (hz.ifid_rs),
    .rt       (hz.ifid_rt),
    .rd       (hz.idex_rd),
    .mem_read (hz.idex_mem_read),
    .load_use (load_use)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    pc_nen     = 1'b0;
    ifid_nen   = 1'b0;
    idex_nen   = 1'b0;
    exmem_nen  = 1'b0;
    memwb_nen  = 1'b0;
    ifid_fl    = 1'b0;
    idex_fl    = 1'b0;

    if (state == HALTED || hz.mem_busy) begin
      pc_nen    = 1'b1;
      ifid_nen  = 1'b1;
      idex_nen  = 1'b1;
      exmem_nen = 1'b1;
      memwb_nen = 1'b1;
    end else if (hz.ex_branch_taken) begin
      // PC stays writable even in DRAIN so the target is kept for resume.
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end else begin
      if (load_use) begin
        pc_nen   = 1'b1;
        ifid_nen = 1'b1;
        idex_fl  = 1'b1;
      end
      // While draining, fetch is blocked on top of any load-use bubble.
      if (state == DRAIN) begin
        pc_nen  = 1'b1;
        ifid_fl = 1'b1;
      end
    end

    case (state)
      RUN: begin
        if (hz.halt_req && !hz.mem_busy) begin
          state_next = DRAIN;
          dcnt_next  = '0;
        end
      end
      DRAIN: begin
        if (!hz.mem_busy && !load_use) begin
          dcnt_next = dcnt + 1'b1;
          if (dcnt == DCNT_LAST) state_next = HALTED;
        end
      end
      HALTED: begin
        if (hz.resume) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign stall_inc = (state != HALTED) &&
                     (hz.mem_busy || (load_use && !hz.ex_branch_taken));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign hz.pc_nen_write    = pc_nen;
  assign hz.ifid_nen_write  = ifid_nen;
  assign hz.idex_nen_write  = idex_nen;
  assign hz.exmem_nen_write = exmem_nen;
  assign hz.memwb_nen_write = memwb_nen;
  assign hz.ifid_flush      = ifid_fl;
  assign hz.idex_flush      = idex_fl;
  assign hz.halted          = (state == HALTED);
  assign hz.stall_count     = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, both checked
// against a behavioural model. A second instance with a 4-bit counter shares
// the same stimulus to exercise saturation.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned DRAIN_N = 4;

  logic clk;
  logic reset;

  pipeline_hazard_ctrl_if #(.reg_addr_w(5), .cnt_w(16)) hz16 ();
  pipeline_hazard_ctrl_if #(.reg_addr_w(5), .cnt_w(4))  hz4 ();

  pipeline_hazard_ctrl #(
    .reg_addr_w(5), .cnt_w(16), .drain_cycles(DRAIN_N)
  ) dut16 (
    .clk(clk), .reset(reset), .hz(hz16)
  );

  pipeline_hazard_ctrl #(
    .reg_addr_w(5), .cnt_w(4), .drain_cycles(DRAIN_N)
  ) dut4 (
    .clk(clk), .reset(reset), .hz(hz4)
  );

  assign hz4.ifid_rs         = hz16.ifid_rs;
  assign hz4.ifid_rt         = hz16.ifid_rt;
  assign hz4.idex_rd         = hz16.idex_rd;
  assign hz4.idex_mem_read   = hz16.idex_mem_read;
  assign hz4.ex_branch_taken = hz16.ex_branch_taken;
  assign hz4.mem_busy        = hz16.mem_busy;
  assign hz4.halt_req        = hz16.halt_req;
  assign hz4.resume          = hz16.resume;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: halted flag, remaining drain steps (0 = not draining),
  // and plain integer stall totals clipped to each counter's maximum.
  bit m_halted;
  int m_drain_left;
  int m_stall16;
  int m_stall4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    hz16.ifid_rs         = '0;
    hz16.ifid_rt         = '0;
    hz16.idex_rd         = '0;
    hz16.idex_mem_read   = 1'b0;
    hz16.ex_branch_taken = 1'b0;
    hz16.mem_busy        = 1'b0;
    hz16.halt_req        = 1'b0;
    hz16.resume          = 1'b0;
  endtask

  task automatic model_reset();
    m_halted     = 1'b0;
    m_drain_left = 0;
    m_stall16    = 0;
    m_stall4     = 0;
  endtask

  function automatic bit is_load_use();
    return hz16.idex_mem_read && (hz16.idex_rd != 0) &&
           ((hz16.idex_rd == hz16.ifid_rs) || (hz16.idex_rd == hz16.ifid_rt));
  endfunction

  // Check outputs for the current inputs, then advance model and DUT by one edge.
  task automatic cycle();
    logic [4:0] exp_nen;
    logic [1:0] exp_fl;
    bit lu;
    @(negedge clk);
    lu = is_load_use();
    exp_nen = 5'b00000;
    exp_fl  = 2'b00;
    if (m_halted || hz16.mem_busy) begin
      exp_nen = 5'b11111;
    end else if (hz16.ex_branch_taken) begin
      exp_fl = 2'b11;
    end else begin
      if (lu) begin
        exp_nen = 5'b11000;
        exp_fl  = 2'b01;
      end
      if (m_drain_left > 0) begin
        exp_nen[4] = 1'b1;
        exp_fl[1]  = 1'b1;
      end
    end
    check("nen", {27'd0, hz16.pc_nen_write, hz16.ifid_nen_write, hz16.idex_nen_write,
                  hz16.exmem_nen_write, hz16.memwb_nen_write}, {27'd0, exp_nen});
    check("flush", {30'd0, hz16.ifid_flush, hz16.idex_flush}, {30'd0, exp_fl});
    check("halted", {31'd0, hz16.halted}, {31'd0, m_halted});
    check("stall16", {16'd0, hz16.stall_count}, m_stall16);
    check("stall4", {28'd0, hz4.stall_count}, m_stall4);

    if (m_halted) begin
      if (hz16.resume) m_halted = 1'b0;
    end else begin
      if (hz16.mem_busy || (lu && !hz16.ex_branch_taken)) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (m_drain_left > 0) begin
        if (!hz16.mem_busy && !lu) begin
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1'b1;
        end
      end else if (hz16.halt_req && !hz16.mem_busy) begin
        m_drain_left = DRAIN_N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    #7;
    check("rst_nen", {27'd0, hz16.pc_nen_write, hz16.ifid_nen_write, hz16.idex_nen_write,
                      hz16.exmem_nen_write, hz16.memwb_nen_write}, 32'd0);
    check("rst_halted", {31'd0, hz16.halted}, 32'd0);
    check("rst_stall", {16'd0, hz16.stall_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // Load-use stall, then the same pattern on register 0
    hz16.idex_mem_read = 1'b1; hz16.idex_rd = 5'd3; hz16.ifid_rs = 5'd3;
    cycle();
    check("lu_cnt", {16'd0, hz16.stall_count}, 32'd1);
    hz16.idex_rd = 5'd0; hz16.ifid_rs = 5'd0;
    cycle();
    check("lu_r0_cnt", {16'd0, hz16.stall_count}, 32'd1);

    // Branch together with a load-use match
    hz16.idex_rd = 5'd7; hz16.ifid_rt = 5'd7; hz16.ex_branch_taken = 1'b1;
    cycle();
    check("br_lu_cnt", {16'd0, hz16.stall_count}, 32'd1);
    idle_inputs();

    // Memory wait holding a taken branch in EX
    hz16.ex_branch_taken = 1'b1; hz16.mem_busy = 1'b1;
    repeat (5) cycle();
    check("mw_cnt", {16'd0, hz16.stall_count}, 32'd6);
    hz16.mem_busy = 1'b0;
    #1;
    check("mw_flush", {30'd0, hz16.ifid_flush, hz16.idex_flush}, 32'd3);
    cycle();
    idle_inputs();

    // Halt pulse, four drain cycles, halted, resume
    hz16.halt_req = 1'b1;
    cycle();
    hz16.halt_req = 1'b0;
    repeat (DRAIN_N) cycle();
    check("halt_flag", {31'd0, hz16.halted}, 32'd1);
    check("halt_nen", {27'd0, hz16.pc_nen_write, hz16.ifid_nen_write, hz16.idex_nen_write,
                       hz16.exmem_nen_write, hz16.memwb_nen_write}, 32'h1f);
    hz16.resume = 1'b1;
    cycle();
    hz16.resume = 1'b0;
    #1;
    check("resume", {31'd0, hz16.halted}, 32'd0);
    cycle();

    // Saturation of the 4-bit counter
    hz16.mem_busy = 1'b1;
    repeat (20) cycle();
    check("sat4", {28'd0, hz4.stall_count}, 32'd15);
    check("sat16", {16'd0, hz16.stall_count}, 32'd26);
    idle_inputs();
    cycle();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      hz16.ifid_rs         = 5'($urandom_range(0, 7));
      hz16.ifid_rt         = 5'($urandom_range(0, 7));
      hz16.idex_rd         = 5'($urandom_range(0, 7));
      hz16.idex_mem_read   = ($urandom_range(0, 1) == 1);
      hz16.ex_branch_taken = ($urandom_range(0, 99) < 15);
      hz16.mem_busy        = ($urandom_range(0, 99) < 15);
      hz16.halt_req        = ($urandom_range(0, 99) < 4);
      hz16.resume          = ($urandom_range(0, 99) < 20);
      cycle();
    end
    idle_inputs();
    cycle();

    // Async reset between edges while draining
    hz16.halt_req = 1'b1;
    cycle();
    hz16.halt_req = 1'b0;
    cycle();
    #2;
    reset = 1'b0;
    #1;
    check("arst_halted", {31'd0, hz16.halted}, 32'd0);
    check("arst_stall", {16'd0, hz16.stall_count}, 32'd0);
    check("arst_stall4", {28'd0, hz4.stall_count}, 32'd0);
    check("arst_run", {29'd0, hz16.pc_nen_write, hz16.ifid_flush, hz16.idex_nen_write}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      hz16.ifid_rs         = 5'($urandom_range(0, 3));
      hz16.ifid_rt         = 5'($urandom_range(0, 3));
      hz16.idex_rd         = 5'($urandom_range(0, 3));
      hz16.idex_mem_read   = ($urandom_range(0, 1) == 1);
      hz16.ex_branch_taken = ($urandom_range(0, 99) < 10);
      hz16.mem_busy        = ($urandom_range(0, 99) < 20);
      hz16.halt_req        = ($urandom_range(0, 99) < 5);
      hz16.resume          = ($urandom_range(0, 99) < 25);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
